// File: rtl/rotate_shift_pipe_if.sv
// Operand and result channels of the rotate/shift lane, each with its own valid/ready handshake.
interface rotate_shift_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
  );
endinterface

// File: rtl/rotate_shift_pipe.sv
// Pipelined rotate/shift lane: every op is rotated on entry, then masked/filled into its final form
// after the last register, with carry, zero and illegal-op flags alongside a pass-through tag.
module rotate_shift_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  rotate_shift_pipe_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_LSL = 3'b010,
    OP_LSR = 3'b011,
    OP_ASR = 3'b100
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t            in_pay;
  stage_t            pay_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  stage_t            last;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  rmask;
  logic              nonzero_amt;

  // The wrap-around term shifts by 1 and then by ~amt so a shift by WIDTH is never formed.
  always_comb begin
    in_pay      = '0;
    in_pay.data = bus.in_data;
    in_pay.amt  = bus.in_amt;
    in_pay.op   = bus.in_op;
    in_pay.tag  = bus.in_tag;
    if (bus.in_op == OP_ROL || bus.in_op == OP_LSL)
      in_pay.rot = (bus.in_data << bus.in_amt) | ((bus.in_data >> 1) >> ~bus.in_amt);
    else
      in_pay.rot = (bus.in_data >> bus.in_amt) | ((bus.in_data << 1) << ~bus.in_amt);
  end

  // A stage may load when it is empty or its own content moves on this cycle.
  always_comb begin
    load = '0;
    load[STAGES-1] = !valid_q[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      load[k] = !valid_q[k] || load[k+1];
  end

  assign bus.in_ready  = load[0] && !rst;
  assign bus.out_valid = valid_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++)
        pay_q[k] <= '0;
    end else begin
      if (load[0]) begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid)
          pay_q[0] <= in_pay;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1])
            pay_q[k] <= pay_q[k-1];
        end
      end
    end
  end

  // Shifts clear (or sign-fill) the bits that wrapped; the carry is the bit that wrapped to the edge.
  always_comb begin
    last          = pay_q[STAGES-1];
    rmask         = ONES >> last.amt;
    nonzero_amt   = last.amt != '0;
    res           = last.rot;
    bus.out_carry = 1'b0;
    bus.out_err   = 1'b0;
    case (last.op)
      OP_ROL: bus.out_carry = nonzero_amt && last.rot[0];
      OP_ROR: bus.out_carry = nonzero_amt && last.rot[WIDTH-1];
      OP_LSL: begin
        res           = last.rot & (ONES << last.amt);
        bus.out_carry = nonzero_amt && last.rot[0];
      end
      OP_LSR: begin
        res           = last.rot & rmask;
        bus.out_carry = nonzero_amt && last.rot[WIDTH-1];
      end
      OP_ASR: begin
        res           = (last.rot & rmask) | ({WIDTH{last.data[WIDTH-1]}} & ~rmask);
        bus.out_carry = nonzero_amt && last.rot[WIDTH-1];
      end
      default: begin
        res         = last.data;
        bus.out_err = 1'b1;
      end
    endcase
    bus.out_data = res;
    bus.out_zero = valid_q[STAGES-1] && (res == '0);
    bus.out_tag  = last.tag;
  end
endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Directed and randomized checks of rotate_shift_pipe against a bit-by-bit reference model.
module tb_rotate_shift_pipe;
  localparam int W  = 64;
  localparam int S  = 2;
  localparam int TW = 4;
  localparam int AW = $clog2(W);

  typedef struct packed {
    logic [W-1:0]  data;
    logic          carry;
    logic          zero;
    logic          err;
    logic [TW-1:0] tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  rotate_shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  rotate_shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Each result bit is taken straight from the operand position the op definition names.
  function automatic res_t model(input logic [W-1:0] d, input logic [AW-1:0] s,
                                 input logic [2:0] op, input logic [TW-1:0] tag);
    res_t r;
    int   sh;
    sh     = int'(s);
    r      = '0;
    r.data = d;
    r.tag  = tag;
    case (op)
      3'b000: begin
        for (int i = 0; i < W; i++) r.data[i] = d[(i - sh + W) % W];
        if (sh != 0) r.carry = r.data[0];
      end
      3'b001: begin
        for (int i = 0; i < W; i++) r.data[i] = d[(i + sh) % W];
        if (sh != 0) r.carry = r.data[W-1];
      end
      3'b010: begin
        for (int i = 0; i < W; i++) begin
          if (i >= sh) r.data[i] = d[i-sh];
          else         r.data[i] = 1'b0;
        end
        if (sh != 0) r.carry = d[W-sh];
      end
      3'b011, 3'b100: begin
        for (int i = 0; i < W; i++) begin
          if (i + sh < W)      r.data[i] = d[i+sh];
          else if (op[2])      r.data[i] = d[W-1];
          else                 r.data[i] = 1'b0;
        end
        if (sh != 0) r.carry = d[sh-1];
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.data == '0);
    return r;
  endfunction

  function automatic res_t observe();
    return {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err, bus.out_tag};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] d, input logic [AW-1:0] s,
                          input logic [2:0] op, input logic [TW-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = s;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  // One op into an empty pipe with out_ready high; returns the result and cycles until out_valid.
  task automatic send_and_wait(input logic [W-1:0] d, input logic [AW-1:0] s, input logic [2:0] op,
                               input logic [TW-1:0] tag, output res_t obs, output int lat);
    bit done;
    obs  = '0;
    lat  = -1;
    done = 1'b0;
    bus.out_ready = 1'b1;
    drive_op(d, s, op, tag);
    cycle();
    bus.in_valid = 1'b0;
    for (int n = 1; n <= 8 && !done; n++) begin
      #1;
      if (bus.out_valid) begin
        obs  = observe();
        lat  = n;
        done = 1'b1;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    else passed++;
    checks++;
    if ({bus.out_valid, observe()} !== '0)
      $display("[TB] FAIL reset_outputs: got valid=%b %h expected all zero", bus.out_valid, observe());
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    else passed++;
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] d, input logic [AW-1:0] s,
                              input logic [2:0] op, input res_t exp);
    res_t obs;
    int   lat;
    send_and_wait(d, s, op, exp.tag, obs, lat);
    checks++;
    if (lat !== S) $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, S);
    else passed++;
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s_result: got %h expected %h", name, obs, exp);
    else passed++;
  endtask

  task automatic test_rotate();
    run_directed("rol4", 64'h8000_0000_0000_0001, 6'd4, 3'b000,
                 '{data: 64'h18, carry: 1'b0, zero: 1'b0, err: 1'b0, tag: 4'd3});
    run_directed("ror0", 64'hDEAD_BEEF_0123_4567, 6'd0, 3'b001,
                 '{data: 64'hDEAD_BEEF_0123_4567, carry: 1'b0, zero: 1'b0, err: 1'b0, tag: 4'd4});
    run_directed("rol63", 64'h1, 6'd63, 3'b000,
                 '{data: 64'h8000_0000_0000_0000, carry: 1'b0, zero: 1'b0, err: 1'b0, tag: 4'd5});
  endtask

  task automatic test_shift();
    run_directed("lsl60", 64'hFF, 6'd60, 3'b010,
                 '{data: 64'hF000_0000_0000_0000, carry: 1'b1, zero: 1'b0, err: 1'b0, tag: 4'd6});
    run_directed("lsr1", 64'h1, 6'd1, 3'b011,
                 '{data: 64'h0, carry: 1'b1, zero: 1'b1, err: 1'b0, tag: 4'd7});
    run_directed("asr63", 64'h8000_0000_0000_0000, 6'd63, 3'b100,
                 '{data: 64'hFFFF_FFFF_FFFF_FFFF, carry: 1'b0, zero: 1'b0, err: 1'b0, tag: 4'd8});
  endtask

  task automatic test_illegal();
    run_directed("illegal110", 64'h1234, 6'd5, 3'b110,
                 '{data: 64'h1234, carry: 1'b0, zero: 1'b0, err: 1'b1, tag: 4'd9});
    run_directed("legal_after", 64'h1234, 6'd4, 3'b011,
                 '{data: 64'h123, carry: 1'b0, zero: 1'b0, err: 1'b0, tag: 4'd10});
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  d [6];
    logic [AW-1:0] s [6];
    logic [2:0]    op [6];
    res_t exp_q[$];
    res_t exp;
    int   sent, got, gaps;
    bit   streaming;
    sent = 0; got = 0; gaps = 0; streaming = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d[i]  = {$urandom(), $urandom()};
      s[i]  = AW'($urandom_range(0, W - 1));
      op[i] = 3'($urandom_range(0, 4));
    end
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (sent < 6) drive_op(d[sent], s[sent], op[sent], TW'(sent));
      else bus.in_valid = 1'b0;
      #1;
      if (cyc >= 3) begin
        exp = (exp_q.size() != 0) ? exp_q[0] : '0;
        checks++;
        if (!bus.out_valid || observe() !== exp)
          $display("[TB] FAIL stall_hold: got valid=%b %h expected valid=1 %h", bus.out_valid, observe(), exp);
        else passed++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(d[sent], s[sent], op[sent], TW'(sent)));
        sent++;
      end
      cycle();
    end
    checks++;
    if (sent !== S) $display("[TB] FAIL stall_accepts: got %0d expected %0d", sent, S);
    else passed++;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b expected 0", bus.in_ready);
    else passed++;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (sent < 6) drive_op(d[sent], s[sent], op[sent], TW'(sent));
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (observe() !== exp) $display("[TB] FAIL stream_result[%0d]: got %h expected %h", got, observe(), exp);
        else passed++;
        got++;
        streaming = 1'b1;
      end else if (streaming) begin
        gaps++;
      end
      if (bus.in_valid && bus.in_ready && sent < 6) begin
        exp_q.push_back(model(d[sent], s[sent], op[sent], TW'(sent)));
        sent++;
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got !== 6) $display("[TB] FAIL stream_count: got %0d expected 6", got);
    else passed++;
    checks++;
    if (gaps !== 0) $display("[TB] FAIL stream_gaps: got %0d expected 0", gaps);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    int ghosts;
    logic [W-1:0] d;
    ghosts = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_op({$urandom(), $urandom()}, AW'($urandom_range(0, W - 1)), 3'($urandom_range(0, 4)), TW'(i + 1));
      cycle();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("[TB] FAIL midreset_in_ready: got %b expected 0", bus.in_ready);
    else passed++;
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, observe()} !== '0)
      $display("[TB] FAIL midreset_outputs: got valid=%b %h expected all zero", bus.out_valid, observe());
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL midreset_ready_after: got %b expected 1", bus.in_ready);
    else passed++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) ghosts++;
      cycle();
      #1;
    end
    checks++;
    if (ghosts !== 0) $display("[TB] FAIL midreset_ghosts: got %0d expected 0", ghosts);
    else passed++;
    d = {$urandom(), $urandom()};
    run_directed("after_reset", d, 6'd17, 3'b001, model(d, 6'd17, 3'b001, 4'd12));
  endtask

  task automatic test_random();
    localparam int N = 60;
    res_t exp_q[$];
    res_t exp;
    logic [W-1:0]  d;
    logic [AW-1:0] s;
    logic [2:0]    op;
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 1000 && got < N; cyc++) begin
      if (sent < N && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: d = '0;
          1: d = '1;
          2: d = 64'h8000_0000_0000_0000;
          default: d = {$urandom(), $urandom()};
        endcase
        case ($urandom_range(0, 3))
          0: s = '0;
          1: s = '1;
          default: s = AW'($urandom_range(0, W - 1));
        endcase
        op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        drive_op(d, s, op, TW'(sent));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (observe() !== exp) $display("[TB] FAIL rand_result[%0d]: got %h expected %h", got, observe(), exp);
        else passed++;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, bus.in_amt, bus.in_op, bus.in_tag));
        sent++;
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got !== N) $display("[TB] FAIL rand_count: got %0d expected %0d", got, N);
    else passed++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rotate();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
